// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic        SEL_PCREL = 1'b0;
    localparam logic        SEL_JALR  = 1'b1;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response handshake
interface fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_target_calc.sv
// fetch_target_calc: redirect target mux/adder, word aligned.
// FETCH_MISALIGN_TRAP_EN adds a flag for targets with bit 1 set.
module fetch_target_calc
    import fetch_pkg::*;
(
    input  logic        redirect_sel,
    input  logic [31:0] br_pc,
    input  logic [31:0] immx,
    input  logic [31:0] jalr_target,
    output logic [31:0] target
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);
    logic [31:0] raw;
    assign raw = (redirect_sel == SEL_JALR) ? (jalr_target & ~32'h1) : br_pc + immx;
    assign target = raw & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = raw[1];
`endif
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem handshake and IF/ID register.
// FETCH_MISALIGN_TRAP_EN adds fetch_misalign and suppresses misaligned redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic        redirect_sel,
    input  logic [31:0] br_pc,
    input  logic [31:0] immx,
    input  logic [31:0] jalr_target,
    fetch_if.master     imem,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        if_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);
    fetch_state_t state, state_nxt;
    logic [31:0] pc, pc_nxt, req_pc, hold_instr, hold_pc, target;
    logic slot_free, gnt_now, take, outstanding, bad_target;

    fetch_target_calc u_target (
        .redirect_sel(redirect_sel),
        .br_pc(br_pc),
        .immx(immx),
        .jalr_target(jalr_target),
        .target(target)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign(bad_target)
`endif
    );
`ifndef FETCH_MISALIGN_TRAP_EN
    assign bad_target = 1'b0;
`endif

    assign slot_free   = !if_valid || !stall;
    assign imem.req    = rst_n && state == REQ && slot_free;
    assign imem.addr   = pc;
    assign gnt_now     = imem.req && imem.gnt;
    assign take        = state == WAIT && imem.rvalid && !redirect;
    // a redirect leaves a response in flight unless it lands in this very cycle
    assign outstanding = gnt_now || ((state == WAIT || state == DRAIN) && !imem.rvalid);

    always_comb begin
        state_nxt = state;
        pc_nxt = pc;
        unique case (state)
            REQ: if (gnt_now) begin
                state_nxt = WAIT;
                pc_nxt = pc + 32'd4;
            end
            WAIT: if (imem.rvalid) state_nxt = slot_free ? REQ : HOLD;
            HOLD: if (slot_free) state_nxt = REQ;
            DRAIN: if (imem.rvalid) state_nxt = REQ;
        endcase
        if (redirect) begin
            state_nxt = outstanding ? DRAIN : REQ;
            pc_nxt = bad_target ? pc : target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
            pc <= RESET_PC;
            req_pc <= '0;
            hold_instr <= NOP_INSTR;
            hold_pc <= '0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            if (gnt_now) req_pc <= pc;
            if (take && !slot_free) begin
                hold_instr <= imem.rdata;
                hold_pc <= req_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            instr_out <= NOP_INSTR;
            pc_out <= '0;
        end else if (redirect) begin
            if_valid <= 1'b0;
            instr_out <= NOP_INSTR;
        end else if (take && slot_free) begin
            if_valid <= 1'b1;
            instr_out <= imem.rdata;
            pc_out <= req_pc;
        end else if (state == HOLD && slot_free) begin
            if_valid <= 1'b1;
            instr_out <= hold_instr;
            pc_out <= hold_pc;
        end else if (!stall) begin
            if_valid <= 1'b0;
            instr_out <= NOP_INSTR;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_misalign <= 1'b0;
        else fetch_misalign <= redirect && bad_target;
    end
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the RISC-V core. It owns the PC and the request/response handshake with instruction memory, and it drives the IF/ID pipeline register (instr_out, pc_out, if_valid) consumed by decode and the immediate extender. It takes redirects from EX: PC-relative targets are br_pc+immx, computed here; JALR targets are passed in.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction shown on instr_out when the IF/ID register is empty or flushed (addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  decode/hazard stall; IF/ID holds its contents
redirect  input  1  taken branch/jump from EX, single-cycle pulse
redirect_sel  input  1  0 = br_pc+immx (branch/JAL), 1 = jalr_target
br_pc  input  32  PC of the redirecting instruction
immx  input  32  sign-extended B/J immediate from the extender
jalr_target  input  32  rs1+imm from the ALU
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid, at least 1 cycle after gnt
imem_rdata  input  32  fetched instruction
instr_out  output  32  IF/ID instruction
pc_out  output  32  IF/ID PC
if_valid  output  1  IF/ID holds a live instruction

Behaviour:
- Reset (asynchronous, rst_n=0) values: pc=RESET_PC, state=REQ, imem_req=0, if_valid=0, instr_out=NOP_INSTR, pc_out=0, hold buffer empty. The first request goes out in the first cycle after rst_n deasserts.
- Redirect target: redirect_sel=0 gives br_pc+immx (32-bit modulo add). redirect_sel=1 gives {jalr_target[31:1],1'b0}.
- At most one request is outstanding.
- imem_req=1 only in state REQ. imem_addr=pc, held stable until gnt.
- State REQ:
  - Enter only when the slot is free: IF/ID empty, or being consumed (!stall), and the hold buffer is empty. Otherwise wait in REQ with req low.
  - On gnt: go to WAIT and set pc=pc+4.
- State WAIT: on rvalid, write {imem_rdata, pc_of_request} into IF/ID if IF/ID is free or being consumed. Otherwise write it into the hold buffer and go to HOLD. Either way, return to REQ.
- State HOLD: when stall drops, move the buffer into IF/ID and go to REQ.
- State DRAIN: discard the next rvalid, then go to REQ.
- IF/ID behaviour:
  - With !stall and no new instruction: if_valid=0 and instr_out=NOP_INSTR.
  - With stall: all IF/ID outputs hold.
- Redirect has priority over stall and over everything else, in the same edge:
  - pc=target.
  - IF/ID flushed: if_valid=0, instr_out=NOP_INSTR.
  - Hold buffer cleared.
  - Next state: DRAIN if a request is outstanding (state WAIT, or REQ with gnt in the redirect cycle); otherwise REQ.
- Redirect coinciding with rvalid in WAIT: the response is discarded and the next state is REQ, not DRAIN.
- Throughput: 1 instruction per cycle is not required. With 1-cycle memory latency the sustained rate is 1 per 2 cycles.
- pc increments wrap 0xFFFF_FFFC to 0x0000_0000.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- When defined: adds output fetch_misalign (1 bit), registered and reset 0. It is set for one cycle after a redirect whose target[1] is 1. That redirect does not update pc and does not issue a fetch; state goes to REQ on the old pc with IF/ID flushed.
- When undefined: no port; target[1:0] are forced to 0 before loading pc.

Decomposition:
- Package fetch_pkg holds:
  - the state enum: REQ, WAIT, HOLD, DRAIN;
  - NOP_INSTR;
  - the redirect_sel encodings: SEL_PCREL=0, SEL_JALR=1.
- One natural sub-module: fetch_target_calc, a combinational mux/adder producing the redirect target (plus the misalign flag when the macro is on).

Test Plan:
- Reset: release rst_n with gnt tied 1 and 1-cycle rvalid → imem_addr sequence 0x0, 0x4, 0x8. pc_out follows 0x0, 0x4. if_valid=0 before the first response.
- Stall: assert stall while IF/ID holds pc 0x4 and the 0x8 response arrives → IF/ID holds 0x4 and state is HOLD with no new req. Release stall → pc_out=0x8 next cycle, then request 0xC.
- Branch: redirect, sel=0, br_pc=0x10, immx=0xFFFF_FFF8 → next imem_addr=0x08. if_valid=0 and instr_out=0x13 in the flush cycle.
- Redirect in WAIT: redirect to 0x40 one cycle before rvalid → that response is dropped, the next request is 0x40, and no stale instruction reaches IF/ID.
- JALR: sel=1, jalr_target=0x0000_0101 → next imem_addr=0x100.
- Macro on: sel=1, jalr_target=0x102 → fetch_misalign pulses 1 cycle, pc unchanged, IF/ID flushed.
